// File: rtl/cache_fill_arbiter_if.sv
// Bundle of cache-side request/fill signals and the shared memory port.
// The arbiter uses the slave view; the environment (caches + memory) uses master.
interface cache_fill_arbiter_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);

  // cache requests
  logic                  ic_miss;
  logic [ADDR_WIDTH-1:0] ic_miss_addr;
  logic                  dc_miss;
  logic [ADDR_WIDTH-1:0] dc_miss_addr;
  logic                  dc_wr;
  logic [ADDR_WIDTH-1:0] dc_wr_addr;
  logic [DATA_WIDTH-1:0] dc_wr_data;

  // shared memory port
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_data_valid;

  // fill return path and status
  logic [DATA_WIDTH-1:0] fill_data;
  logic [WORD_BITS-1:0]  fill_word;
  logic                  ic_fill_we;
  logic                  dc_fill_we;
  logic                  ic_fill_done;
  logic                  dc_fill_done;
  logic                  dc_wr_done;
  logic                  busy;

  modport slave (
    input  ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
    input  dc_wr, dc_wr_addr, dc_wr_data,
    input  mem_data_out, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_word, ic_fill_we, dc_fill_we,
    output ic_fill_done, dc_fill_done, dc_wr_done, busy
  );

  modport master (
    output ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
    output dc_wr, dc_wr_addr, dc_wr_data,
    output mem_data_out, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_word, ic_fill_we, dc_fill_we,
    input  ic_fill_done, dc_fill_done, dc_wr_done, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single memory port between icache and dcache.
// Block fills are issued as back-to-back word reads; dcache stores are
// single-cycle write-throughs. Round-robin between the two caches.
module cache_fill_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_arbiter_if.slave  bus
);
  localparam int WORD_BITS   = $clog2(WORDS_PER_BLOCK);
  // byte offset of a block: word index plus the 16-bit word byte select
  localparam int OFFSET_BITS = WORD_BITS + 1;

  localparam logic [WORD_BITS:0]   BLOCK_WORDS = (WORD_BITS+1)'(WORDS_PER_BLOCK);
  localparam logic [WORD_BITS-1:0] LAST_WORD   = WORD_BITS'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  grant_ic_reg, grant_ic_next;   // 1 = icache owns the current op
  logic                  prio_ic_reg, prio_ic_next;     // 1 = icache wins the next tie
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [WORD_BITS:0]    issue_cnt_reg, issue_cnt_next; // one extra bit to reach BLOCK_WORDS
  logic [WORD_BITS-1:0]  recv_cnt_reg, recv_cnt_next;

  logic dc_req;
  logic dc_wins;

  assign dc_req  = bus.dc_wr | bus.dc_miss;
  // dcache takes the port when alone or when it holds the round-robin turn
  assign dc_wins = dc_req & (~bus.ic_miss | ~prio_ic_reg);

  // State and datapath registers; reset returns to IDLE with dcache priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_ic_reg  <= 1'b0;
      prio_ic_reg   <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_ic_reg  <= grant_ic_next;
      prio_ic_reg   <= prio_ic_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  // Next-state logic and all outputs; outputs stay 0 unless a state drives them
  always_comb begin
    state_next     = state_reg;
    grant_ic_next  = grant_ic_reg;
    prio_ic_next   = prio_ic_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    issue_cnt_next = issue_cnt_reg;
    recv_cnt_next  = recv_cnt_reg;

    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.fill_data    = '0;
    bus.fill_word    = '0;
    bus.ic_fill_we   = 1'b0;
    bus.dc_fill_we   = 1'b0;
    bus.ic_fill_done = 1'b0;
    bus.dc_fill_done = 1'b0;
    bus.dc_wr_done   = 1'b0;
    bus.busy         = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        issue_cnt_next = '0;
        recv_cnt_next  = '0;
        if (dc_wins) begin
          grant_ic_next = 1'b0;
          // a pending store goes ahead of a dcache fill
          if (bus.dc_wr) begin
            state_next = WRITE;
            addr_next  = bus.dc_wr_addr;
            wdata_next = bus.dc_wr_data;
          end else begin
            state_next = FILL;
            addr_next  = bus.dc_miss_addr;
          end
        end else if (bus.ic_miss) begin
          grant_ic_next = 1'b1;
          state_next    = FILL;
          addr_next     = bus.ic_miss_addr;
        end
      end

      FILL: begin
        // issue side: one read per cycle, word index replaces the block offset
        // so the address can never carry out of the block
        if (issue_cnt_reg < BLOCK_WORDS) begin
          bus.mem_en     = 1'b1;
          bus.mem_addr   = {addr_reg[ADDR_WIDTH-1:OFFSET_BITS],
                            issue_cnt_reg[WORD_BITS-1:0], 1'b0};
          issue_cnt_next = issue_cnt_reg + (WORD_BITS+1)'(1);
        end
        // receive side: words return in issue order
        if (bus.mem_data_valid) begin
          bus.fill_data  = bus.mem_data_out;
          bus.fill_word  = recv_cnt_reg;
          bus.ic_fill_we = grant_ic_reg;
          bus.dc_fill_we = ~grant_ic_reg;
          recv_cnt_next  = recv_cnt_reg + WORD_BITS'(1);
          if (recv_cnt_reg == LAST_WORD) begin
            bus.ic_fill_done = grant_ic_reg;
            bus.dc_fill_done = ~grant_ic_reg;
            state_next       = DONE;
          end
        end
      end

      WRITE: begin
        bus.mem_en     = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = addr_reg;
        bus.mem_wdata  = wdata_reg;
        bus.dc_wr_done = 1'b1;
        state_next     = DONE;
      end

      DONE: begin
        // dead cycle lets the finished requester drop its level request;
        // the turn passes to the cache that was not just served
        prio_ic_next = ~grant_ic_reg;
        state_next   = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr_done;
  } iss_t;

  typedef struct packed {
    logic          ic_we;
    logic          dc_we;
    logic [2:0]    word;
    logic [DW-1:0] data;
    logic          ic_done;
    logic          dc_done;
  } fill_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_ic_done = 0, exp_dc_done = 0, exp_wr_done = 0;
  int   got_ic_done = 0, got_dc_done = 0, got_wr_done = 0;
  iss_t  iss_q[$];
  fill_t fill_q[$];

  always #5 clk = ~clk;

  cache_fill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB)) bus ();

  cache_fill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // memory model: read issued in cycle c returns in cycle c+LAT; flushed by rst
  logic          rd_v [LAT];
  logic [AW-1:0] rd_a [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) rd_v[k] <= 1'b0;
    end else begin
      rd_v[0] <= bus.mem_en && !bus.mem_wr;
      rd_a[0] <= bus.mem_addr;
      for (int k = 1; k < LAT; k++) begin
        rd_v[k] <= rd_v[k-1];
        rd_a[k] <= rd_a[k-1];
      end
    end
  end
  assign bus.mem_data_valid = rd_v[LAT-1];
  assign bus.mem_data_out   = rd_v[LAT-1] ? mem_word(rd_a[LAT-1]) : '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
                bus.fill_word, bus.ic_fill_we, bus.dc_fill_we, bus.ic_fill_done,
                bus.dc_fill_done, bus.dc_wr_done, bus.busy});
  endfunction

  // expected reads (n_iss of them) and returned words (n_fill of them) for one fill
  task automatic push_fill(input logic ic, input logic [AW-1:0] addr,
                           input int n_iss, input int n_fill);
    logic [AW-1:0] base;
    iss_t  ie;
    fill_t fe;
    base = addr & 16'hFFF0;
    for (int i = 0; i < n_iss; i++) begin
      ie.wr = 1'b0; ie.addr = base + 16'(2*i); ie.wdata = '0; ie.wr_done = 1'b0;
      iss_q.push_back(ie);
    end
    for (int i = 0; i < n_fill; i++) begin
      fe.ic_we   = ic;
      fe.dc_we   = !ic;
      fe.word    = 3'(i);
      fe.data    = mem_word(base + 16'(2*i));
      fe.ic_done = ic && (i == WPB-1);
      fe.dc_done = !ic && (i == WPB-1);
      fill_q.push_back(fe);
    end
    if (n_fill == WPB) begin
      if (ic) exp_ic_done++; else exp_dc_done++;
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    iss_t ie;
    ie.wr = 1'b1; ie.addr = addr; ie.wdata = data; ie.wr_done = 1'b1;
    iss_q.push_back(ie);
    exp_wr_done++;
  endtask

  // monitor: pop and compare on every memory access and every fill write
  always @(negedge clk) begin
    iss_t  o_iss, e_iss;
    fill_t o_fill, e_fill;
    if (mon_en) begin
      if (bus.mem_en) begin
        o_iss.wr = bus.mem_wr; o_iss.addr = bus.mem_addr;
        o_iss.wdata = bus.mem_wdata; o_iss.wr_done = bus.dc_wr_done;
        check_eq("iss_expected", 64'(iss_q.size() != 0), 64'd1);
        if (iss_q.size() != 0) begin
          e_iss = iss_q.pop_front();
          check_eq("mem_access", 64'(o_iss), 64'(e_iss));
        end
      end else begin
        check_eq("idle_mem_bus", 64'({bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.dc_wr_done}), 64'd0);
      end
      if (bus.ic_fill_we || bus.dc_fill_we) begin
        o_fill.ic_we = bus.ic_fill_we; o_fill.dc_we = bus.dc_fill_we;
        o_fill.word = bus.fill_word; o_fill.data = bus.fill_data;
        o_fill.ic_done = bus.ic_fill_done; o_fill.dc_done = bus.dc_fill_done;
        check_eq("fill_expected", 64'(fill_q.size() != 0), 64'd1);
        if (fill_q.size() != 0) begin
          e_fill = fill_q.pop_front();
          check_eq("fill_word", 64'(o_fill), 64'(e_fill));
        end
      end else begin
        check_eq("idle_fill_done", 64'({bus.ic_fill_done, bus.dc_fill_done}), 64'd0);
      end
      got_ic_done += int'(bus.ic_fill_done);
      got_dc_done += int'(bus.dc_fill_done);
      got_wr_done += int'(bus.dc_wr_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for a done pulse: 0 ic fill, 1 dc fill, 2 store, 3 either fill
  task automatic wait_done(input int which, output int n, output logic got_ic);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      tick();
      n++;
      case (which)
        0:       hit = bus.ic_fill_done;
        1:       hit = bus.dc_fill_done;
        2:       hit = bus.dc_wr_done;
        default: hit = bus.ic_fill_done | bus.dc_fill_done;
      endcase
    end
    got_ic = bus.ic_fill_done;
    check_eq($sformatf("wait%0d_seen", which), 64'(hit), 64'd1);
  endtask

  // finish the DONE cycle and land in IDLE
  task automatic settle(input string tag);
    tick();
    tick();
    check_eq(tag, 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [AW-1:0] dc_addr(input int k);
    return 16'h3000 + 16'(k*32);
  endfunction

  function automatic logic [AW-1:0] ic_addr(input int k);
    return 16'h0804 + 16'(k*32);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic gi;
    int   kd, ki;

    bus.ic_miss = 0; bus.ic_miss_addr = '0;
    bus.dc_miss = 0; bus.dc_miss_addr = '0;
    bus.dc_wr = 0; bus.dc_wr_addr = '0; bus.dc_wr_data = '0;

    // reset
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // lone icache fill, unaligned address
    push_fill(1'b1, 16'h1236, 8, 8);
    bus.ic_miss = 1; bus.ic_miss_addr = 16'h1236;
    wait_done(0, n, gi);
    check_eq("t1_fill_latency", 64'(n), 64'd12);
    bus.ic_miss = 0;
    settle("t1_idle");

    // simultaneous requests: dcache first, icache at done+2
    push_fill(1'b0, 16'h2000, 8, 8);
    push_fill(1'b1, 16'h0100, 8, 8);
    bus.dc_miss = 1; bus.dc_miss_addr = 16'h2000;
    bus.ic_miss = 1; bus.ic_miss_addr = 16'h0100;
    wait_done(1, n, gi);
    check_eq("t2_dc_latency", 64'(n), 64'd12);
    bus.dc_miss = 0;
    wait_done(0, n, gi);
    check_eq("t2_ic_after_dc", 64'(n), 64'd14);
    bus.ic_miss = 0;
    settle("t2_idle");

    // both held: strict alternation dc, ic, dc, ic ...
    for (int k = 0; k < 4; k++) begin
      push_fill(1'b0, dc_addr(k), 8, 8);
      push_fill(1'b1, ic_addr(k), 8, 8);
    end
    bus.dc_miss = 1; bus.dc_miss_addr = dc_addr(0);
    bus.ic_miss = 1; bus.ic_miss_addr = ic_addr(0);
    kd = 1;
    ki = 1;
    for (int t = 0; t < 8; t++) begin
      wait_done(3, n, gi);
      check_eq($sformatf("t3_gap%0d", t), 64'(n), (t == 0) ? 64'd12 : 64'd14);
      if (gi) begin
        if (ki < 4) bus.ic_miss_addr = ic_addr(ki); else bus.ic_miss = 0;
        ki++;
      end else begin
        if (kd < 4) bus.dc_miss_addr = dc_addr(kd); else bus.dc_miss = 0;
        kd++;
      end
    end
    bus.ic_miss = 0;
    bus.dc_miss = 0;
    settle("t3_idle");

    // store beats a simultaneous dcache fill; busy lasts exactly 2 cycles
    push_wr(16'h4002, 16'hBEEF);
    push_fill(1'b0, 16'h6008, 8, 8);
    bus.dc_wr = 1; bus.dc_wr_addr = 16'h4002; bus.dc_wr_data = 16'hBEEF;
    bus.dc_miss = 1; bus.dc_miss_addr = 16'h6008;
    wait_done(2, n, gi);
    check_eq("t4_wr_latency", 64'(n), 64'd1);
    check_eq("t4_busy_write", 64'(bus.busy), 64'd1);
    bus.dc_wr = 0;
    tick();
    check_eq("t4_busy_done", 64'(bus.busy), 64'd1);
    tick();
    check_eq("t4_busy_idle", 64'(bus.busy), 64'd0);
    wait_done(1, n, gi);
    check_eq("t4_fill_latency", 64'(n), 64'd12);
    bus.dc_miss = 0;
    settle("t4_idle");

    // reset after the third word of a dcache fill
    push_fill(1'b0, 16'h5000, 7, 3);
    bus.dc_miss = 1; bus.dc_miss_addr = 16'h5000;
    repeat (7) tick();
    check_eq("t5_third_word", 64'({bus.dc_fill_we, bus.fill_word}), 64'({1'b1, 3'd2}));
    rst = 1'b1;
    bus.dc_miss = 0;
    tick();
    check_eq("t5_rst_outs", all_outs(), 64'd0);
    rst = 1'b0;
    push_fill(1'b1, 16'h0040, 8, 8);
    bus.ic_miss = 1; bus.ic_miss_addr = 16'h0040;
    wait_done(0, n, gi);
    check_eq("t5_ic_latency", 64'(n), 64'd12);
    bus.ic_miss = 0;
    settle("t5_idle");

    // top-of-memory block, no wrap
    push_fill(1'b0, 16'hFFFA, 8, 8);
    bus.dc_miss = 1; bus.dc_miss_addr = 16'hFFFA;
    wait_done(1, n, gi);
    check_eq("t6_dc_latency", 64'(n), 64'd12);
    bus.dc_miss = 0;
    settle("t6_idle");

    // reset returns the turn to the dcache even though icache was next
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_fill(1'b0, 16'h7000, 8, 8);
    push_fill(1'b1, 16'h0900, 8, 8);
    bus.dc_miss = 1; bus.dc_miss_addr = 16'h7000;
    bus.ic_miss = 1; bus.ic_miss_addr = 16'h0900;
    wait_done(1, n, gi);
    check_eq("t7_dc_first", 64'(n), 64'd12);
    bus.dc_miss = 0;
    wait_done(0, n, gi);
    check_eq("t7_ic_next", 64'(n), 64'd14);
    bus.ic_miss = 0;
    settle("t7_idle");

    repeat (4) tick();
    check_eq("iss_q_drained", 64'(iss_q.size()), 64'd0);
    check_eq("fill_q_drained", 64'(fill_q.size()), 64'd0);
    check_eq("ic_done_count", 64'(got_ic_done), 64'(exp_ic_done));
    check_eq("dc_done_count", 64'(got_dc_done), 64'(exp_dc_done));
    check_eq("wr_done_count", 64'(got_wr_done), 64'(exp_wr_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shares the single L2/main-memory port between the instruction cache and the data cache.
- Grants one requester at a time and sequences block fills as WORDS_PER_BLOCK pipelined word reads.
- Issues single-cycle write-through stores for the dcache.
- Sits between the two cache controllers and the shared memory model; the cache hit/request counters are driven by its requesters, not by this block.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 16, word width
WORDS_PER_BLOCK, 8, words per cache block (power of 2)
MEM_LATENCY, 4, cycles from read issue to mem_data_valid (at least 1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
ic_miss  in  1  icache fill request (level)
ic_miss_addr  in  ADDR_WIDTH  icache miss byte address
dc_miss  in  1  dcache fill request (level)
dc_miss_addr  in  ADDR_WIDTH  dcache miss byte address
dc_wr  in  1  dcache write-through store request (level)
dc_wr_addr  in  ADDR_WIDTH  store byte address
dc_wr_data  in  DATA_WIDTH  store data
mem_en  out  1  memory access this cycle
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  memory byte address
mem_wdata  out  DATA_WIDTH  memory write data
mem_data_out  in  DATA_WIDTH  memory read data
mem_data_valid  in  1  read data valid
fill_data  out  DATA_WIDTH  returned word, shared by both caches
fill_word  out  log2(WORDS_PER_BLOCK)  word index within the block
ic_fill_we  out  1  write fill_data into the icache line
dc_fill_we  out  1  write fill_data into the dcache line
ic_fill_done  out  1  icache fill complete pulse
dc_fill_done  out  1  dcache fill complete pulse
dc_wr_done  out  1  store complete pulse
busy  out  1  state is not IDLE

Behaviour:
- Reset: rst is synchronous and active-high, sampled on posedge clk.
  - State goes to IDLE; issue and receive counters clear; round-robin pointer resets to DC.
  - The cycle after rst is sampled high, every output is 0.
  - rst mid-fill or mid-write aborts the operation with no done pulse.
  - The memory model flushes in-flight reads on the same rst.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE arbitration (registered; grant effective next cycle):
  - dc_wr and dc_miss form one dcache request; dc_wr beats dc_miss if both are high.
  - Dcache vs icache is round-robin: pointer starts at DC and flips to the other requester after each completed grant.
  - A lone requester is always granted.
  - The request address is latched at grant; requester address changes afterwards are ignored.
- FILL:
  - Block base = addr with the low log2(2*WORDS_PER_BLOCK) bits cleared.
  - Issue: in grant cycles g+1 .. g+WORDS_PER_BLOCK, drive mem_en=1, mem_wr=0, mem_addr = base + 2*i for i = 0..WORDS_PER_BLOCK-1, one word per cycle.
  - Address arithmetic never carries out of the block (base 0xFFF0 reaches 0xFFFE, no wrap).
  - Receive: on each mem_data_valid, fill_data = mem_data_out and fill_word = receive count; the granted cache's *_fill_we = 1 for that cycle; the receive count increments.
  - The last word (count = WORDS_PER_BLOCK-1) also asserts the matching *_fill_done in the same cycle; next state is DONE.
  - mem_data_valid outside FILL is ignored.
  - The non-granted cache's fill_we and done stay 0.
- WRITE: exactly one cycle with mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data and dc_wr_done=1; next state is DONE.
- DONE:
  - One dead cycle; no requests are sampled, so requesters drop their level request in the cycle after their done pulse.
  - Next state is IDLE.
- Latency:
  - Fill completes with done at cycle g+WORDS_PER_BLOCK+MEM_LATENCY (g+12 at defaults).
  - Store completes with done at g+1.
  - The earliest next grant is made in IDLE at done+2.
- Outputs are combinational from registered state and counters, plus mem_data_valid and mem_data_out.
  - mem_addr and mem_wdata are 0 whenever mem_en=0.
  - busy = (state != IDLE).

Test Plan:
1. ic_miss at 0x1236 alone, granted at cycle g -> mem_addr 0x1230, 0x1232 .. 0x123E in cycles g+1..g+8; ic_fill_we with fill_word 0..7 in g+5..g+12; ic_fill_done at g+12; dc_* outputs stay 0.
2. ic_miss (0x0100) and dc_miss (0x2000) raised in the same cycle after reset -> dcache filled first (addresses 0x2000..0x200E); icache fill issues 0x0100 after DONE and IDLE; exactly one done pulse each.
3. dc_miss held continuously with ic_miss pending -> after the dc fill, the ic fill is granted before the second dc grant (round-robin), with no starvation over 4 alternations.
4. dc_wr to 0x4002 with data 0xBEEF -> one cycle of mem_en=1, mem_wr=1, mem_addr 0x4002, mem_wdata 0xBEEF and dc_wr_done=1; busy high for exactly 2 cycles.
5. rst asserted after 3 words of a dcache fill -> the next cycle all outputs are 0 and state is IDLE, with no dc_fill_done; a subsequent ic_miss at 0x0040 completes cleanly with 8 words indexed 0..7.
6. dc_miss at 0xFFFA -> addresses 0xFFF0..0xFFFE with no wrap to 0x0000; dc_fill_done after fill_word 7.
